// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: parameter defaults,
// the clear-sweep state encoding and the packed-port slicing helper.
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_RD_DEF  = 2;
  localparam int ZERO_R0_DEF = 1;
  localparam int BYPASS_DEF  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Low bit of port 'idx' inside a flattened bus of 'width'-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Read ports are flattened: port i lives at [i*W +: W].
interface regfile_multiport_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int NUM_RD = regfile_pkg::NUM_RD_DEF
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Hardware clear sweep: once started it writes zero to every entry, one per
// cycle from entry 0 upward, and then falls back to IDLE. A single pass only.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next state and sweep write request; clr_req only matters while idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_we   = 1'b0;
    sweep_addr = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        sweep_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write per cycle (port or clear sweep),
// NUM_RD registered read ports with optional write bypass and zero register.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF,
  parameter int BYPASS  = BYPASS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_multiport_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              sweep_busy;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  logic              port_we;
  logic              int_we;
  logic [ADDR_W-1:0] int_addr;
  logic [DATA_W-1:0] int_data;

  logic [ADDR_W-1:0] rd_addr_w  [NUM_RD];
  logic [DATA_W-1:0] rd_data_q  [NUM_RD];
  logic [DATA_W-1:0] rd_data_d  [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q, rd_valid_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_flat;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_req   (bus.clr_req),
    .busy      (sweep_busy),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  // Pick the single internal write: the sweep owns the array while busy,
  // otherwise the port, except that entry 0 is protected when hard-wired.
  always_comb begin
    port_we  = bus.wr_en && !sweep_busy && !((ZERO_R0 != 0) && (bus.wr_addr == '0));
    int_we   = port_we;
    int_addr = bus.wr_addr;
    int_data = bus.wr_data;
    if (sweep_busy) begin
      int_we   = sweep_we;
      int_addr = sweep_addr;
      int_data = '0;
    end
  end

  // Next array contents after the internal write.
  always_comb begin
    mem_d = mem_q;
    if (int_we) begin
      mem_d[int_addr] = int_data;
    end
  end

  // Storage array; reset clears every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Unpack the per-port read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_w[i] = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    end
  end

  // Per-port read data: zero register first, then bypass, then the array.
  always_comb begin
    rd_valid_d = bus.rd_en;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_d[i] = rd_data_q[i];
      if (bus.rd_en[i]) begin
        if ((ZERO_R0 != 0) && (rd_addr_w[i] == '0)) begin
          rd_data_d[i] = '0;
        end else if ((BYPASS != 0) && int_we && (int_addr == rd_addr_w[i])) begin
          rd_data_d[i] = int_data;
        end else begin
          rd_data_d[i] = mem_q[rd_addr_w[i]];
        end
      end
    end
  end

  // Read output registers; data holds when a port is not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_q[i] <= rd_data_d[i];
      end
    end
  end

  // Flatten read data back onto the bus.
  always_comb begin
    rd_data_flat = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_flat[slice_lo(i, DATA_W) +: DATA_W] = rd_data_q[i];
    end
  end

  assign bus.rd_data  = rd_data_flat;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = sweep_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport. Two instances share one stimulus
// stream: dut_a with zero register and bypass, dut_b with neither.
module tb_regfile_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
  regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();

  regfile_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(1)
  ) dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_a)
  );

  regfile_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0), .BYPASS(0)
  ) dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_b)
  );

  // Reference state: plain arrays plus a "sweep in progress / next index" pair.
  logic [31:0] model_mem [2][DEPTH];
  int          model_busy;
  int          model_idx;

  rd_exp_t     exp_q [4][$];
  logic        busy_exp_q [$];
  logic [31:0] last_data [4];

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus_a.rd_en = '0; bus_a.rd_addr = '0; bus_a.wr_en = 1'b0;
    bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.clr_req = 1'b0;
    bus_b.rd_en = '0; bus_b.rd_addr = '0; bus_b.wr_en = 1'b0;
    bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.clr_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < DEPTH; k++) model_mem[d][k] = '0;
    for (int q = 0; q < 4; q++) last_data[q] = '0;
    model_busy = 0;
    model_idx  = 0;
  endtask

  // One clock of stimulus: drive at the falling edge, then record what the
  // following rising edge must produce and advance the model past it.
  task automatic apply_stimulus(input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic clr);
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  ra;
    logic [31:0] e;
    rd_exp_t     item;
    @(negedge clk);
    bus_a.rd_en = ren; bus_a.rd_addr = {a1, a0}; bus_a.wr_en = we;
    bus_a.wr_addr = wa; bus_a.wr_data = wd; bus_a.clr_req = clr;
    bus_b.rd_en = ren; bus_b.rd_addr = {a1, a0}; bus_b.wr_en = we;
    bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.clr_req = clr;
    for (int d = 0; d < 2; d++) begin
      if (model_busy != 0) begin
        w_en = 1'b1; w_addr = 5'(model_idx); w_data = '0;
      end else begin
        w_en = we && !(d == 0 && wa == 5'd0); w_addr = wa; w_data = wd;
      end
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          ra = (p == 1) ? a1 : a0;
          if (d == 0 && ra == 5'd0)                    e = '0;
          else if (d == 0 && w_en && w_addr == ra)     e = w_data;
          else                                         e = model_mem[d][ra];
          item.cyc  = cyc + 1;
          item.data = e;
          exp_q[d*2+p].push_back(item);
        end
      end
      if (w_en) model_mem[d][w_addr] = w_data;
    end
    if (model_busy != 0) begin
      if (model_idx == DEPTH - 1) begin
        model_busy = 0; model_idx = 0;
      end else begin
        model_idx++;
      end
    end else if (clr) begin
      model_busy = 1; model_idx = 0;
    end
    busy_exp_q.push_back(model_busy != 0);
  endtask

  // Monitor body: pop read expectations when a port shows valid, otherwise
  // require the data to hold; compare busy every stimulated cycle.
  task automatic check_output();
    logic        v;
    logic [31:0] dat;
    rd_exp_t     item;
    logic        b;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        int q;
        q   = d * 2 + p;
        v   = (d == 0) ? bus_a.rd_valid[p] : bus_b.rd_valid[p];
        dat = (d == 0) ? bus_a.rd_data[p*DW +: DW] : bus_b.rd_data[p*DW +: DW];
        n_vec++;
        if (v) begin
          if (exp_q[q].size() == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected_valid dut%0d port%0d: got data %h, no read outstanding", d, p, dat);
          end else begin
            item = exp_q[q].pop_front();
            last_data[q] = item.data;
            if (item.cyc != cyc || dat !== item.data) begin
              n_err++;
              $display("[TB] FAIL rd_data dut%0d port%0d: got %h at cycle %0d, expected %h at cycle %0d",
                       d, p, dat, cyc, item.data, item.cyc);
            end
          end
        end else if (exp_q[q].size() > 0 && exp_q[q][0].cyc <= cyc) begin
          n_err++;
          item = exp_q[q].pop_front();
          last_data[q] = item.data;
          $display("[TB] FAIL missing_valid dut%0d port%0d: rd_valid 0 at cycle %0d, expected 1 with %h",
                   d, p, cyc, item.data);
        end else if (dat !== last_data[q]) begin
          n_err++;
          $display("[TB] FAIL rd_hold dut%0d port%0d: got %h expected %h", d, p, dat, last_data[q]);
        end
      end
    end
    if (busy_exp_q.size() > 0) begin
      b = busy_exp_q.pop_front();
      check_val("busy_a", 64'(bus_a.busy), 64'(b));
      check_val("busy_b", 64'(bus_b.busy), 64'(b));
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) check_output();
  end

  // Asynchronous reset in the middle of a cycle, with immediate output checks.
  task automatic reset_now();
    @(negedge clk);
    #2;
    drive_idle();
    reset_n = 1'b0;
    model_reset();
    busy_exp_q.delete();
    for (int q = 0; q < 4; q++) exp_q[q].delete();
    #1;
    check_val("rst_busy_a",  64'(bus_a.busy),     64'd0);
    check_val("rst_busy_b",  64'(bus_b.busy),     64'd0);
    check_val("rst_valid_a", 64'(bus_a.rd_valid), 64'd0);
    check_val("rst_valid_b", 64'(bus_b.rd_valid), 64'd0);
    check_val("rst_data_a",  bus_a.rd_data,       64'd0);
    check_val("rst_data_b",  bus_b.rd_data,       64'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_busy_a",  64'(bus_a.busy),     64'd0);
    check_val("rst_valid_a", 64'(bus_a.rd_valid), 64'd0);
    check_val("rst_data_a",  bus_a.rd_data,       64'd0);
    check_val("rst_data_b",  bus_b.rd_data,       64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Directed: reset read, write-then-read, bypass, zero register.
    apply_stimulus(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    apply_stimulus(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    apply_stimulus(2'b10, 5'd0, 5'd3, 1'b1, 5'd3, 32'h12345678, 1'b0);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    apply_stimulus(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    apply_stimulus(2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);

    // Fill with index+1, sweep while reading entry 31 and attempting writes.
    for (int k = 0; k < DEPTH; k++)
      apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'(k), 32'(k + 1), 1'b0);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      apply_stimulus(2'b11, 5'(k), 5'd31, 1'b1, 5'($urandom), $urandom, 1'(k == 5));
    for (int k = 0; k < DEPTH; k += 2)
      apply_stimulus(2'b11, 5'(k), 5'(k + 1), 1'b0, 5'd0, 32'h0, 1'b0);

    // Randomised traffic with occasional sweeps.
    for (int n = 0; n < 400; n++)
      apply_stimulus(2'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                     5'($urandom), $urandom, 1'($urandom_range(0, 63) == 0));
    for (int n = 0; n < 40 && model_busy != 0; n++)
      apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);

    // Reset ten cycles into a sweep, then confirm a fresh sweep starts at 0.
    for (int k = 0; k < 8; k++)
      apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'(k), 32'hA500 + 32'(k), 1'b0);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++)
      apply_stimulus(2'b01, 5'd20, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    reset_now();
    for (int k = 0; k < DEPTH; k += 2)
      apply_stimulus(2'b11, 5'(k), 5'(k + 1), 1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 1; k < 4; k++)
      apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'(k), 32'hC0DE0000 + 32'(k), 1'b0);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++)
      apply_stimulus(2'b11, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0);

    repeat (3) apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    for (int q = 0; q < 4; q++) begin
      n_vec++;
      if (exp_q[q].size() != 0) begin
        n_err++;
        $display("[TB] FAIL drain queue%0d: %0d reads outstanding, expected 0", q, exp_q[q].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the CPU's 32×32 register file: configurable data width, depth and number of read ports, with registered reads, optional same-cycle write-to-read bypass, an optional hard-wired zero register, and a sequential hardware clear sweep. It sits between decode (read addresses) and writeback (write port) in the datapath. The default parameters replace the current two-read/one-write register file.

## Interface
- DATA_W, 32, data width of each entry
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (≥1)
- ZERO_R0, 1, 1: entry 0 is read-only and always reads 0
- BYPASS, 1, 1: read of the address being written in the same cycle returns the new data
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  port i data updated this cycle
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  start the clear sweep (single-cycle pulse or level; sampled only in IDLE)
- busy  out  1  clear sweep in progress

## Operation
- Reset (reset_n low, asynchronous): all entries 0, rd_data 0, rd_valid 0, busy 0, FSM in IDLE, sweep counter 0. Reset during a sweep aborts it.
- Write path: one internal write per cycle, sourced from either the port or the sweep.
  - Port write is accepted when wr_en=1, busy=0, and not (ZERO_R0=1 and wr_addr=0).
  - While busy=1, port writes are dropped with no error flag.
- Reads (each port independent): when rd_en[i]=1 at an edge, rd_data[i] loads the entry content and rd_valid[i] is set for one cycle. When rd_en[i]=0, rd_data[i] holds and rd_valid[i] is 0.
  - Read of address 0 with ZERO_R0=1 returns 0.
  - If BYPASS=1 and the internal write in the same cycle targets rd_addr[i], rd_data[i] gets the written value. This applies to port writes and sweep writes alike.
  - If BYPASS=0, the read returns the pre-write content.
- Multiple ports may read the same address in the same cycle; all return identical data.
- Clear FSM:
  - IDLE: on clr_req=1, go to CLEAR with counter 0; busy goes high.
  - CLEAR: each cycle, write 0 to entry[counter] and increment. Reads remain legal. When counter reaches DEPTH-1 and that write completes, return to IDLE; busy goes low.
  - clr_req is ignored while in CLEAR.
- clr_req and wr_en in the same IDLE cycle: the port write is accepted, then the sweep zeroes that entry.
- The counter is ADDR_W bits wide; the terminal condition is counter == DEPTH-1, with no wrap into a second pass.

## Timing
- Read latency: 1 cycle. Address at edge N produces rd_data and rd_valid valid after edge N.
- Write visible to a non-bypassed read at edge N+1 when written at edge N.
- Clear: clr_req sampled at edge T0. busy=1 after T0. Entry k is zeroed at edge T0+1+k. busy=0 after edge T0+DEPTH. Total busy duration is DEPTH cycles.
- First port write is accepted at edge T0+DEPTH+1.
- No combinational path from inputs to outputs.

## Structure
- Package regfile_pkg holds:
  - FSM state enum {IDLE, CLEAR}
  - default parameter constants
  - helper function computing port slice offsets
- Sub-module regfile_clear_fsm (state, counter, busy, sweep write address/enable) is natural. The top level holds the array, write mux and read ports (generate loop over NUM_RD).

## Test plan
- Reset then read: release reset_n, read addr 5 on both ports → rd_data=0, rd_valid=2'b11 one cycle later.
- Write then read: write 0xDEADBEEF to 7 at edge N, read 7 at edge N+1 → 0xDEADBEEF.
- Bypass: write 0x12345678 to 3 while port 1 reads 3 in the same cycle.
  - BYPASS=1 → 0x12345678.
  - BYPASS=0 → prior value 0.
- Zero register: write 0xFFFFFFFF to 0, read 0 → 0.
  - With ZERO_R0=0 → 0xFFFFFFFF.
- Clear sweep:
  - Fill all 32 entries with index+1, pulse clr_req → busy high exactly 32 cycles.
  - wr_en during busy is dropped.
  - Afterwards every entry reads 0.
  - A read of entry 31 mid-sweep returns 32 before its edge and 0 after.
- Reset mid-sweep: assert reset_n low at sweep cycle 10 → busy=0 immediately, all entries 0, FSM IDLE, and the next clr_req restarts from entry 0.
